// File: rtl/instfifo_if.sv
// Handshake bundle between fetch, the instruction queue and the decoder/RS/ROB.
// The queue itself sits on the slave side; fetch and the downstream units form the master.
interface instfifo_if #(
  parameter int ADDR_W = 3,
  parameter int INST_W = 32,
  parameter int PC_W   = 32
);
  logic              if_instqueue_en_in;
  logic [INST_W-1:0] if_instqueue_inst_in;
  logic [PC_W-1:0]   if_instqueue_pc_in;
  logic              instqueue_if_rdy_out;
  logic              rs_instqueue_rdy_in;
  logic              rob_instqueue_rdy_in;
  logic              rob_instqueue_rst_in;
  logic              decoder_instqueue_rst_in;
  logic              instqueue_decoder_en_out;
  logic [INST_W-1:0] instqueue_decoder_inst_out;
  logic [PC_W-1:0]   instqueue_decoder_pc_out;
  logic [ADDR_W:0]   instqueue_count_out;
  logic              instqueue_overflow_out;

  modport master (
    output if_instqueue_en_in, if_instqueue_inst_in, if_instqueue_pc_in,
    output rs_instqueue_rdy_in, rob_instqueue_rdy_in,
    output rob_instqueue_rst_in, decoder_instqueue_rst_in,
    input  instqueue_if_rdy_out, instqueue_decoder_en_out,
    input  instqueue_decoder_inst_out, instqueue_decoder_pc_out,
    input  instqueue_count_out, instqueue_overflow_out
  );

  modport slave (
    input  if_instqueue_en_in, if_instqueue_inst_in, if_instqueue_pc_in,
    input  rs_instqueue_rdy_in, rob_instqueue_rdy_in,
    input  rob_instqueue_rst_in, decoder_instqueue_rst_in,
    output instqueue_if_rdy_out, instqueue_decoder_en_out,
    output instqueue_decoder_inst_out, instqueue_decoder_pc_out,
    output instqueue_count_out, instqueue_overflow_out
  );
endinterface

// File: rtl/instfifo.sv
// Instruction queue between fetch and decode: circular buffer with explicit occupancy,
// slack-aware fetch back-pressure, sticky overflow and single-cycle flush.
module instfifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int SLACK  = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  instfifo_if.slave  bus
);

  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] RDY_LIMIT = (ADDR_W+1)'(DEPTH - SLACK);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   count;
  logic              en_q;
  logic [INST_W-1:0] inst_q;
  logic [PC_W-1:0]   pc_q;
  logic              overflow_q;

  logic flush;
  logic full;
  logic empty;
  logic push_fire;
  logic pop_fire;

  // Full/empty come from the explicit count, so head==tail is never ambiguous.
  always_comb begin
    flush     = bus.rob_instqueue_rst_in || bus.decoder_instqueue_rst_in;
    full      = (count == FULL_CNT);
    empty     = (count == '0);
    push_fire = bus.if_instqueue_en_in && !full;
    pop_fire  = bus.rs_instqueue_rdy_in && bus.rob_instqueue_rdy_in && !empty;
  end

  // Storage has no reset; stale entries are unreachable once the pointers are cleared.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush && push_fire) begin
      inst_mem[tail] <= bus.if_instqueue_inst_in;
      pc_mem[tail]   <= bus.if_instqueue_pc_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      en_q       <= 1'b0;
      inst_q     <= '0;
      pc_q       <= '0;
      overflow_q <= 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        en_q       <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        if (push_fire) begin
          tail <= tail + 1'b1;
        end
        if (pop_fire) begin
          head   <= head + 1'b1;
          en_q   <= 1'b1;
          inst_q <= inst_mem[head];
          pc_q   <= pc_mem[head];
        end else begin
          en_q <= 1'b0;
        end
        if (push_fire && !pop_fire) begin
          count <= count + 1'b1;
        end else if (!push_fire && pop_fire) begin
          count <= count - 1'b1;
        end
        // Full test uses the pre-edge count, so a same-cycle pop cannot rescue the push.
        if (bus.if_instqueue_en_in && full) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  assign bus.instqueue_if_rdy_out       = (count < RDY_LIMIT);
  assign bus.instqueue_decoder_en_out   = en_q;
  assign bus.instqueue_decoder_inst_out = inst_q;
  assign bus.instqueue_decoder_pc_out   = pc_q;
  assign bus.instqueue_count_out        = count;
  assign bus.instqueue_overflow_out     = overflow_q;

endmodule

// File: tb/tb_instfifo.sv
// Self-checking bench for instfifo: hand-derived vector table, directed corner sequences
// and a randomized phase compared against a queue-based reference model.
module tb_instfifo;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam int SLACK  = 1;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b0;

  instfifo_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .PC_W(PC_W)) bus ();

  instfifo #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W), .PC_W(PC_W), .SLACK(SLACK)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rdy;
    logic        push;
    logic [31:0] pc;
    logic        rs;
    logic        rob;
    logic        rob_rst;
    logic        dec_rst;
    logic [3:0]  exp_count;
    logic        exp_en;
    logic [31:0] exp_pc;
    logic        exp_ovf;
    logic        exp_ifrdy;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue plus the registered output view.
  ent_t        mq[$];
  logic        m_en;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic        m_ovf;

  vec_t vecs[19];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  function automatic vec_t mkVec(input logic push, input logic [31:0] pc, input logic rs,
                                 input logic rob_rst, input logic [3:0] c, input logic en,
                                 input logic [31:0] opc, input logic ovf, input logic ifrdy);
    vec_t v;
    v.rdy = 1'b1; v.push = push; v.pc = pc; v.rs = rs; v.rob = rs;
    v.rob_rst = rob_rst; v.dec_rst = 1'b0;
    v.exp_count = c; v.exp_en = en; v.exp_pc = opc; v.exp_ovf = ovf; v.exp_ifrdy = ifrdy;
    return v;
  endfunction

  task automatic modelReset();
    mq.delete();
    m_en = 1'b0; m_inst = '0; m_pc = '0; m_ovf = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently presented.
  task automatic modelStep();
    logic do_pop;
    logic was_full;
    ent_t e;
    if (!rdy_in) return;
    if (bus.rob_instqueue_rst_in || bus.decoder_instqueue_rst_in) begin
      mq.delete();
      m_en  = 1'b0;
      m_ovf = 1'b0;
      return;
    end
    do_pop   = bus.rs_instqueue_rdy_in && bus.rob_instqueue_rdy_in && (mq.size() != 0);
    was_full = (mq.size() == DEPTH);
    if (do_pop) begin
      e = mq.pop_front();
      m_en = 1'b1; m_inst = e.inst; m_pc = e.pc;
    end else begin
      m_en = 1'b0;
    end
    if (bus.if_instqueue_en_in) begin
      if (was_full) m_ovf = 1'b1;
      else begin
        e.inst = bus.if_instqueue_inst_in;
        e.pc   = bus.if_instqueue_pc_in;
        mq.push_back(e);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic push, input logic [31:0] pc,
                               input logic rs, input logic rob, input logic rrst,
                               input logic drst);
    rdy_in                       = rdy;
    bus.if_instqueue_en_in       = push;
    bus.if_instqueue_pc_in       = pc;
    bus.if_instqueue_inst_in     = inst_of(pc);
    bus.rs_instqueue_rdy_in      = rs;
    bus.rob_instqueue_rdy_in     = rob;
    bus.rob_instqueue_rst_in     = rrst;
    bus.decoder_instqueue_rst_in = drst;
    modelStep();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "_count"}, 32'(bus.instqueue_count_out), 32'(mq.size()));
    chk({tag, "_en"},    32'(bus.instqueue_decoder_en_out), 32'(m_en));
    chk({tag, "_pc"},    bus.instqueue_decoder_pc_out, m_pc);
    chk({tag, "_inst"},  bus.instqueue_decoder_inst_out, m_inst);
    chk({tag, "_ovf"},   32'(bus.instqueue_overflow_out), 32'(m_ovf));
    chk({tag, "_ifrdy"}, 32'(bus.instqueue_if_rdy_out), 32'((mq.size() + SLACK) < DEPTH));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++)
      vecs[i] = mkVec(1'b1, 32'(4*i), 1'b0, 1'b0, 4'(i+1), 1'b0, 32'h0, 1'b0, (i + 2 < 8));
    vecs[8] = mkVec(1'b1, 32'h40, 1'b0, 1'b0, 4'd8, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int j = 0; j < 8; j++)
      vecs[9+j] = mkVec(1'b0, 32'h0, 1'b1, 1'b0, 4'(7-j), 1'b1, 32'(4*j), 1'b1, (j > 0));
    vecs[17] = mkVec(1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b0, 32'h1C, 1'b1, 1'b1);
    vecs[18] = mkVec(1'b0, 32'h0, 1'b1, 1'b1, 4'd0, 1'b0, 32'h1C, 1'b0, 1'b1);

    rst_in = 1'b1;
    rdy_in = 1'b1;
    bus.if_instqueue_en_in = 1'b0; bus.if_instqueue_pc_in = '0; bus.if_instqueue_inst_in = '0;
    bus.rs_instqueue_rdy_in = 1'b0; bus.rob_instqueue_rdy_in = 1'b0;
    bus.rob_instqueue_rst_in = 1'b0; bus.decoder_instqueue_rst_in = 1'b0;
    modelReset();
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    chk("reset_count", 32'(bus.instqueue_count_out), 32'd0);
    chk("reset_en",    32'(bus.instqueue_decoder_en_out), 32'd0);
    chk("reset_pc",    bus.instqueue_decoder_pc_out, 32'd0);
    chk("reset_inst",  bus.instqueue_decoder_inst_out, 32'd0);
    chk("reset_ovf",   32'(bus.instqueue_overflow_out), 32'd0);
    chk("reset_ifrdy", 32'(bus.instqueue_if_rdy_out), 32'd1);

    // Fill, overflow, drain and flush from the table.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].rdy, vecs[i].push, vecs[i].pc, vecs[i].rs, vecs[i].rob,
                    vecs[i].rob_rst, vecs[i].dec_rst);
      chk($sformatf("vec%0d_count", i), 32'(bus.instqueue_count_out), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_en", i),    32'(bus.instqueue_decoder_en_out), 32'(vecs[i].exp_en));
      chk($sformatf("vec%0d_pc", i),    bus.instqueue_decoder_pc_out, vecs[i].exp_pc);
      chk($sformatf("vec%0d_ovf", i),   32'(bus.instqueue_overflow_out), 32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_ifrdy", i), 32'(bus.instqueue_if_rdy_out), 32'(vecs[i].exp_ifrdy));
      checkOutput($sformatf("vec%0d_model", i));
    end

    // Push into an empty queue with downstream ready: one cycle of residency, no bypass.
    applyStimulus(1, 1, 32'h100, 1, 1, 0, 0);
    chk("empty_push_en", 32'(bus.instqueue_decoder_en_out), 32'd0);
    chk("empty_push_count", 32'(bus.instqueue_count_out), 32'd1);
    applyStimulus(1, 0, 32'h0, 1, 1, 0, 0);
    chk("empty_pop_en", 32'(bus.instqueue_decoder_en_out), 32'd1);
    chk("empty_pop_pc", bus.instqueue_decoder_pc_out, 32'h100);
    checkOutput("empty_pop");

    // Steady push+pop at occupancy 3 across pointer wrap.
    for (int n = 0; n < 3; n++) applyStimulus(1, 1, 32'h200 + 32'(4*n), 0, 0, 0, 0);
    chk("conc_fill_count", 32'(bus.instqueue_count_out), 32'd3);
    for (int j = 0; j < 20; j++) begin
      applyStimulus(1, 1, 32'h200 + 32'(4*(j+3)), 1, 1, 0, 0);
      chk($sformatf("conc%0d_count", j), 32'(bus.instqueue_count_out), 32'd3);
      chk($sformatf("conc%0d_pc", j), bus.instqueue_decoder_pc_out, 32'h200 + 32'(4*j));
      checkOutput($sformatf("conc%0d", j));
    end
    applyStimulus(1, 0, 32'h0, 0, 0, 1, 0);
    checkOutput("conc_flush");

    // Overflow at full, then decoder flush with a same-cycle push and pop.
    for (int n = 0; n < 8; n++) applyStimulus(1, 1, 32'h400 + 32'(4*n), 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h40, 0, 0, 0, 0);
    chk("ovf_set", 32'(bus.instqueue_overflow_out), 32'd1);
    chk("ovf_count", 32'(bus.instqueue_count_out), 32'd8);
    applyStimulus(1, 1, 32'h500, 1, 1, 0, 1);
    chk("ovf_flush_ovf", 32'(bus.instqueue_overflow_out), 32'd0);
    chk("ovf_flush_count", 32'(bus.instqueue_count_out), 32'd0);
    chk("ovf_flush_en", 32'(bus.instqueue_decoder_en_out), 32'd0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 0, 32'h0, 1, 1, 0, 0);
      chk($sformatf("ovf_after%0d_en", k), 32'(bus.instqueue_decoder_en_out), 32'd0);
    end

    // Mid-stream flush with a concurrent push, from each flush source.
    for (int src = 0; src < 2; src++) begin
      for (int n = 0; n < 5; n++) applyStimulus(1, 1, 32'h600 + 32'(4*n), 0, 0, 0, 0);
      chk($sformatf("mid%0d_count5", src), 32'(bus.instqueue_count_out), 32'd5);
      applyStimulus(1, 1, 32'h700, 1, 1, (src == 0), (src == 1));
      chk($sformatf("mid%0d_count", src), 32'(bus.instqueue_count_out), 32'd0);
      chk($sformatf("mid%0d_en", src), 32'(bus.instqueue_decoder_en_out), 32'd0);
      for (int k = 0; k < 2; k++) begin
        applyStimulus(1, 0, 32'h0, 1, 1, 0, 0);
        chk($sformatf("mid%0d_after%0d_en", src, k), 32'(bus.instqueue_decoder_en_out), 32'd0);
      end
    end

    // Push right after a flush is accepted; build occupancy 3 with en_out high.
    applyStimulus(1, 1, 32'h800, 0, 0, 0, 0);
    chk("post_flush_push", 32'(bus.instqueue_count_out), 32'd1);
    applyStimulus(1, 1, 32'h804, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h808, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h80C, 1, 1, 0, 0);
    checkOutput("pre_freeze");

    // Global enable low freezes everything, including flush.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 32'h900 + 32'(k), 1, 1, (k == 1), (k == 3));
      chk($sformatf("freeze%0d_count", k), 32'(bus.instqueue_count_out), 32'd3);
      chk($sformatf("freeze%0d_en", k), 32'(bus.instqueue_decoder_en_out), 32'd1);
      chk($sformatf("freeze%0d_pc", k), bus.instqueue_decoder_pc_out, 32'h800);
      checkOutput($sformatf("freeze%0d", k));
    end
    applyStimulus(1, 0, 32'h0, 1, 1, 0, 0);
    chk("unfreeze_pc", bus.instqueue_decoder_pc_out, 32'h804);

    // Asynchronous reset between clock edges.
    #3;
    rst_in = 1'b1;
    #1;
    chk("areset_count", 32'(bus.instqueue_count_out), 32'd0);
    chk("areset_en",    32'(bus.instqueue_decoder_en_out), 32'd0);
    chk("areset_pc",    bus.instqueue_decoder_pc_out, 32'd0);
    chk("areset_inst",  bus.instqueue_decoder_inst_out, 32'd0);
    chk("areset_ovf",   32'(bus.instqueue_overflow_out), 32'd0);
    modelReset();
    #2;
    rst_in = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(9) != 0), ($urandom_range(9) < 6), $urandom,
                    ($urandom_range(9) < 7), ($urandom_range(9) < 7),
                    ($urandom_range(49) == 0), ($urandom_range(49) == 0));
      checkOutput($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instfifo.md
# instfifo

Parametrised instruction queue between instruction fetch and the decoder. It buffers fetched instruction/PC pairs and issues them one per cycle to the decoder whenever both the reservation station and the reorder buffer can accept. It adds four things: full-depth occupancy tracking, a fetch-slack back-pressure threshold, a sticky overflow flag and an occupancy output. Flushes from the ROB (mispredict) or the decoder (jump redirect) empty the queue in one cycle.

## Interface
- DEPTH, 8: number of entries; power of two, at least 2.
- ADDR_W, 3: log2(DEPTH); pointer width.
- INST_W, 32: instruction width.
- PC_W, 32: PC width.
- SLACK, 1: fetches IF may still have in flight after the ready signal drops; 0 ≤ SLACK < DEPTH.

Ports:
- clk_in  in  1  system clock; all state on rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- rdy_in  in  1  global enable; low freezes all state and outputs.
- if_instqueue_en_in  in  1  push request.
- if_instqueue_inst_in  in  INST_W  instruction to push.
- if_instqueue_pc_in  in  PC_W  PC to push.
- instqueue_if_rdy_out  out  1  combinational; high when count + SLACK < DEPTH.
- rs_instqueue_rdy_in  in  1  reservation station can accept.
- rob_instqueue_rdy_in  in  1  reorder buffer can accept.
- rob_instqueue_rst_in  in  1  flush request from the ROB.
- decoder_instqueue_rst_in  in  1  flush request from the decoder.
- instqueue_decoder_en_out  out  1  registered; output entry valid this cycle.
- instqueue_decoder_inst_out  out  INST_W  registered instruction.
- instqueue_decoder_pc_out  out  PC_W  registered PC.
- instqueue_count_out  out  ADDR_W+1  current occupancy, 0..DEPTH.
- instqueue_overflow_out  out  1  sticky; a push was attempted while the queue was full.

## Operation
- Storage: circular arrays inst[DEPTH] and pc[DEPTH].
- Pointers: head and tail, ADDR_W bits each. Wrap-around is the natural ADDR_W-bit overflow.
- count is an explicit ADDR_W+1-bit register. Empty is count==0; full is count==DEPTH. head==tail alone never decides full/empty.
- Push: fires when if_instqueue_en_in && count<DEPTH.
  - Writes inst[tail] and pc[tail], then tail+1.
  - A push while count==DEPTH is dropped and sets overflow.
- Pop: fires when rs_instqueue_rdy_in && rob_instqueue_rdy_in && count!=0.
  - Loads the output registers from inst[head]/pc[head], sets en_out=1, then head+1.
  - Otherwise en_out=0 and the data outputs hold their previous values.
- Simultaneous push and pop:
  - Both fire and count is unchanged.
  - At count==DEPTH the push is still dropped, because the full check uses the pre-edge count.
  - At count==0 only the push fires; there is no bypass.
- Flush (rob_instqueue_rst_in || decoder_instqueue_rst_in, sampled with rdy_in=1):
  - head, tail and count go to 0; en_out goes to 0; overflow is cleared.
  - A push or pop in the same cycle is discarded.
  - Array contents need not be cleared.
- rdy_in=0: no state changes, including flush and push; all outputs hold.
- Reset (asynchronous):
  - Immediately: head=tail=count=0, en_out=0, inst_out=0, pc_out=0, overflow=0.
  - Reset asserted mid-operation abandons all entries.
  - Array contents are don't-care.

## Timing
- Push sampled at edge k: the entry is poppable at edge k+1 at the earliest. Its en_out/data are visible during the cycle after edge k+1 (one-cycle minimum residency).
- Throughput: one push and one pop per cycle.
- instqueue_if_rdy_out: combinational from count only, valid in the same cycle.
- IF must stop issuing within SLACK cycles of the ready signal going low. Pushes beyond that are lost and flagged.
- instqueue_count_out: reflects the registered count, so it updates the cycle after each push/pop.
- Flush at edge f: en_out=0 from edge f. A push presented at edge f+1 is accepted normally.

## Test plan
- Fill and drain, DEPTH=8, SLACK=1, both downstream ready low:
  - Push 8 entries with PC 0x00..0x1C. Ready drops once count=7; count reaches 8; overflow stays 0.
  - Raise both readies: 8 consecutive en_out pulses with PCs in order 0x00..0x1C; count returns to 0.
- Overflow: at count=8, push PC 0x40 → dropped; overflow=1, count stays 8. Flush → overflow=0, count=0.
- Concurrent push/pop at count=3 for 20 cycles → count stays 3; PCs emerge strictly in push order across pointer wrap.
- Empty-queue push with downstream ready: push PC 0x100 at edge k → en_out=0 after edge k; en_out=1 with pc_out=0x100 after edge k+1.
- Flush mid-stream: count=5 and a push in the same cycle as rob_instqueue_rst_in → count=0, en_out=0 next cycle, pushed entry never appears. Repeat using decoder_instqueue_rst_in.
- rdy_in low for 4 cycles during push/pop/flush activity → no change in count, pointers or outputs. Asynchronous rst_in pulse between edges → all outputs 0 immediately.
